// File: rtl/simon_pkg.sv
// Shared types for the Simon Says round logic: FSM state encoding, symbol type
// and a small constant helper used to size the shared phase timer.
package simon_pkg;

  localparam int SYM_W_DEF = 2;

  typedef logic [SYM_W_DEF-1:0] sym_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SHOW   = 3'd2,
    ST_GAP    = 3'd3,
    ST_ARM    = 3'd4,
    ST_LISTEN = 3'd5,
    ST_DONE   = 3'd6
  } rseq_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by the SHOW, GAP and LISTEN phases.
// Load wins over enable; the count saturates at zero.
module seq_timer #(
  parameter int MAX_VAL = 20,
  parameter int W       = $clog2(MAX_VAL + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/round_sequencer.sv
// Plays the first round_len pattern symbols to the display, then checks keypad
// entries against the same memory entries; reports pass/fail with a done pulse.
module round_sequencer
  import simon_pkg::*;
#(
  parameter int MAX_LEN        = 10,
  parameter int SYM_W          = 2,
  parameter int ADDR_W         = 4,
  parameter int ON_CYCLES      = 3,
  parameter int OFF_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] round_len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [SYM_W-1:0]  mem_data,
  output logic [SYM_W-1:0]  disp_sym,
  output logic              disp_valid,
  input  logic              key_strobe,
  input  logic [SYM_W-1:0]  key_sym,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [2:0]        state
);

  localparam int TMAX = max3(ON_CYCLES, OFF_CYCLES, TIMEOUT_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0]     ON_LOAD   = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]     OFF_LOAD  = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0]     TO_LOAD   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] MAX_LEN_A = ADDR_W'(MAX_LEN);

  rseq_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [SYM_W-1:0]  exp_q, exp_d;
  logic [SYM_W-1:0]  disp_sym_q, disp_sym_d;
  logic              disp_valid_q, disp_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;

  logic              tmr_load, tmr_en, tmr_zero;
  logic [TW-1:0]     tmr_val;
  logic              last_idx;
  logic [ADDR_W-1:0] idx_inc;

  seq_timer #(
    .MAX_VAL (TMAX),
    .W       (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  assign last_idx = (idx_q == (len_q - 1'b1));
  assign idx_inc  = idx_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    mem_addr_d   = mem_addr_q;
    exp_d        = exp_q;
    disp_sym_d   = disp_sym_q;
    disp_valid_d = disp_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_d       = fail_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    tmr_en       = 1'b0;

    if (abort) begin
      // Abort leaves the previous verdict visible and never pulses done.
      disp_valid_d = 1'b0;
      busy_d       = 1'b0;
      mem_addr_d   = '0;
      state_d      = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && (round_len != '0) && (round_len <= MAX_LEN_A)) begin
            len_d      = round_len;
            idx_d      = '0;
            mem_addr_d = '0;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
            busy_d     = 1'b1;
            state_d    = ST_FETCH;
          end
        end
        ST_FETCH: begin
          disp_sym_d   = mem_data;
          disp_valid_d = 1'b1;
          tmr_load     = 1'b1;
          tmr_val      = ON_LOAD;
          state_d      = ST_SHOW;
        end
        ST_SHOW: begin
          if (tmr_zero) begin
            disp_valid_d = 1'b0;
            tmr_load     = 1'b1;
            tmr_val      = OFF_LOAD;
            state_d      = ST_GAP;
          end else begin
            tmr_en = 1'b1;
          end
        end
        ST_GAP: begin
          if (tmr_zero) begin
            if (last_idx) begin
              idx_d      = '0;
              mem_addr_d = '0;
              state_d    = ST_ARM;
            end else begin
              idx_d      = idx_inc;
              mem_addr_d = idx_inc;
              state_d    = ST_FETCH;
            end
          end else begin
            tmr_en = 1'b1;
          end
        end
        ST_ARM: begin
          exp_d    = mem_data;
          tmr_load = 1'b1;
          tmr_val  = TO_LOAD;
          state_d  = ST_LISTEN;
        end
        ST_LISTEN: begin
          // A keypress on the final timer cycle still counts as a keypress.
          if (key_strobe) begin
            if (key_sym == exp_q) begin
              if (last_idx) begin
                pass_d  = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
              end else begin
                idx_d      = idx_inc;
                mem_addr_d = idx_inc;
                state_d    = ST_ARM;
              end
            end else begin
              fail_d  = 1'b1;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end else if (tmr_zero) begin
            fail_d  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            tmr_en = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      mem_addr_q   <= '0;
      exp_q        <= '0;
      disp_sym_q   <= '0;
      disp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      mem_addr_q   <= mem_addr_d;
      exp_q        <= exp_d;
      disp_sym_q   <= disp_sym_d;
      disp_valid_q <= disp_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign disp_sym   = disp_sym_q;
  assign disp_valid = disp_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign state      = state_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Randomized scoreboard bench for round_sequencer: the driver derives expected
// display/done events from the round rules, a negedge monitor checks them.
module tb_round_sequencer;
  import simon_pkg::*;

  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int TO  = 20;
  localparam int P   = 1 + ON + OFF;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] round_len = '0;
  logic [3:0] mem_addr;
  sym_t       mem_data;
  sym_t       disp_sym;
  logic       disp_valid;
  logic       key_strobe = 1'b0;
  sym_t       key_sym = '0;
  logic       busy, done, pass, fail;
  logic [2:0] state;

  sym_t mem [0:15];
  assign mem_data = mem[mem_addr];

  round_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .round_len  (round_len),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .disp_sym   (disp_sym),
    .disp_valid (disp_valid),
    .key_strobe (key_strobe),
    .key_sym    (key_sym),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int sym; } disp_exp_t;
  typedef struct { int cyc; bit p; bit f; } done_exp_t;
  typedef struct { int cyc; int sym; } ev_t;

  disp_exp_t exp_disp[$];
  done_exp_t exp_done[$];

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  cut_cnt = 0;
  bit  m_pass = 1'b0;
  bit  m_fail = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, expv, cyc);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT lights a symbol or pulses done.
  bit prev_dv = 1'b0, prev_done = 1'b0;
  int dv_run = 0, done_run = 0, cut_seen = 0;
  always @(negedge clk) begin
    disp_exp_t de;
    done_exp_t ce;
    if (disp_valid && !prev_dv) begin
      if (exp_disp.size() == 0) begin
        chk("disp_unexpected", 1, 0);
      end else begin
        de = exp_disp.pop_front();
        chk("disp_cycle", cyc, de.cyc);
        chk("disp_sym", int'(disp_sym), de.sym);
        $display("disp  cyc=%0d sym=%0d", cyc, disp_sym);
      end
    end
    if (!disp_valid && prev_dv) begin
      if (cut_cnt != cut_seen) cut_seen = cut_cnt;
      else chk("disp_on_len", dv_run, ON);
    end
    dv_run = disp_valid ? dv_run + 1 : 0;
    if (done && !prev_done) begin
      if (exp_done.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        ce = exp_done.pop_front();
        chk("done_cycle", cyc, ce.cyc);
        chk("done_pass", int'(pass), int'(ce.p));
        chk("done_fail", int'(fail), int'(ce.f));
        chk("done_busy", int'(busy), 0);
        $display("done  cyc=%0d pass=%0d fail=%0d", cyc, pass, fail);
      end
    end
    if (!done && prev_done) chk("done_width", done_run, 1);
    done_run = done ? done_run + 1 : 0;
    prev_dv   = disp_valid;
    prev_done = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic do_start(input int len, output int base);
    chk("held_pass", int'(pass), int'(m_pass));
    chk("held_fail", int'(fail), int'(m_fail));
    start = 1'b1;
    round_len = 4'(len);
    tick();
    start = 1'b0;
    base = cyc - 1;
    chk("start_state", int'(state), 1);
    chk("start_busy", int'(busy), 1);
    chk("start_pass", int'(pass), 0);
    chk("start_fail", int'(fail), 0);
    m_pass = 1'b0;
    m_fail = 1'b0;
    for (int i = 0; i < len; i++) exp_disp.push_back('{base + 2 + i * P, int'(mem[i])});
  endtask

  // mode 0: all keys correct; 1: wrong key at index j; 2: timeout at index j.
  task automatic run_round(input int len, input int mode, input int j, input bit junk,
                           input int fixed_d, input bit arm_chk);
    int base, lst, d, done_c, sym;
    bit rp;
    ev_t evq[$];
    do_start(len, base);
    lst = len * P + 2;
    done_c = 0;
    rp = 1'b0;
    if (junk) evq.push_back('{2 + int'($urandom_range(0, len * P - 2)), int'($urandom_range(0, 3))});
    for (int k = 0; k < len; k++) begin
      if (junk && $urandom_range(0, 1) == 1) evq.push_back('{lst - 1, int'($urandom_range(0, 3))});
      if (fixed_d >= 0) d = fixed_d;
      else begin
        case ($urandom_range(0, 3))
          0: d = 0;
          1: d = TO - 1;
          default: d = int'($urandom_range(0, TO - 1));
        endcase
      end
      if (mode == 2 && k == j) begin
        done_c = lst + TO;
        break;
      end
      sym = int'(mem[k]);
      if (mode == 1 && k == j) sym = sym ^ int'($urandom_range(1, 3));
      evq.push_back('{lst + d, sym});
      if (mode == 1 && k == j) begin
        done_c = lst + d + 1;
        break;
      end
      if (k == len - 1) begin
        done_c = lst + d + 1;
        rp = 1'b1;
        break;
      end
      lst = lst + d + 2;
    end
    exp_done.push_back('{base + done_c, rp, !rp});
    $display("round len=%0d mode=%0d j=%0d expect_done=%0d pass=%0d", len, mode, j, done_c, rp);
    if (arm_chk) begin
      wait_until(base + len * P + 1);
      chk("arm_state", int'(state), 4);
      wait_until(base + len * P + 2);
      chk("listen_state", int'(state), 5);
    end
    foreach (evq[i]) begin
      wait_until(base + evq[i].cyc);
      key_strobe = 1'b1;
      key_sym = 2'(evq[i].sym);
      tick();
      key_strobe = 1'b0;
    end
    wait_until(base + done_c + 1);
    chk("done_pending", exp_done.size(), 0);
    chk("disp_pending", exp_disp.size(), 0);
    chk("end_state", int'(state), 0);
    chk("end_busy", int'(busy), 0);
    exp_done.delete();
    exp_disp.delete();
    m_pass = rp;
    m_fail = !rp;
  endtask

  task automatic bad_start(input int len);
    start = 1'b1;
    round_len = 4'(len);
    tick();
    start = 1'b0;
    tick();
    chk("badlen_state", int'(state), 0);
    chk("badlen_busy", int'(busy), 0);
    chk("badlen_pass", int'(pass), int'(m_pass));
    chk("badlen_fail", int'(fail), int'(m_fail));
    $display("badlen len=%0d state=%0d", len, state);
  endtask

  task automatic set_mem_rand();
    for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_addr"}, int'(mem_addr), 0);
    chk({tag, "_dsym"}, int'(disp_sym), 0);
    chk({tag, "_dvalid"}, int'(disp_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_fail"}, int'(fail), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    set_mem_rand();
    // Reset held two cycles while start is asserted.
    rst = 1'b0;
    start = 1'b1;
    round_len = 4'd3;
    tick();
    tick();
    check_all_zero("reset");
    start = 1'b0;
    rst = 1'b1;
    tick();
    chk("post_reset_state", int'(state), 0);

    mem[0] = 2'd2; mem[1] = 2'd1; mem[2] = 2'd3;
    run_round(3, 0, 0, 1'b0, 0, 1'b1);
    tick();
    chk("pass_held", int'(pass), 1);
    run_round(3, 1, 1, 1'b1, 0, 1'b0);
    run_round(3, 2, 0, 1'b0, 0, 1'b0);
    run_round(3, 0, 0, 1'b0, TO - 1, 1'b0);
    run_round(3, 2, 2, 1'b1, TO - 1, 1'b0);

    bad_start(0);
    bad_start(11);
    bad_start(15);

    set_mem_rand();
    run_round(10, 0, 0, 1'b1, -1, 1'b0);
    run_round(1, 0, 0, 1'b1, -1, 1'b0);

    // Abort during the first SHOW.
    do_start(4, base);
    wait_until(base + 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cut_cnt++;
    exp_disp.delete();
    chk("abort_dvalid", int'(disp_valid), 0);
    chk("abort_state", int'(state), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_addr", int'(mem_addr), 0);
    chk("abort_pass", int'(pass), int'(m_pass));
    chk("abort_fail", int'(fail), int'(m_fail));
    $display("abort cyc=%0d state=%0d", cyc, state);
    repeat (10) tick();
    chk("abort_idle", int'(state), 0);

    for (int r = 0; r < 25; r++) begin
      int len, mode;
      set_mem_rand();
      len = int'($urandom_range(1, 10));
      mode = int'($urandom_range(0, 2));
      run_round(len, mode, int'($urandom_range(0, len - 1)), 1'b1, -1, 1'b0);
    end

    // Reset in the middle of playback, then reset in IDLE after a pass.
    do_start(5, base);
    wait_until(base + 9);
    rst = 1'b0;
    start = 1'b1;
    tick();
    cut_cnt++;
    exp_disp.delete();
    check_all_zero("midreset");
    tick();
    rst = 1'b1;
    start = 1'b0;
    m_pass = 1'b0;
    m_fail = 1'b0;
    tick();
    mem[0] = 2'd2; mem[1] = 2'd1; mem[2] = 2'd3;
    run_round(3, 0, 0, 1'b0, 0, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_all_zero("idlereset");
    m_pass = 1'b0;
    m_fail = 1'b0;

    repeat (5) tick();
    chk("final_done_q", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
